// File: rtl/kill_rst_seq.sv
// Reset sequencer: turns monitor kill requests into a timed core reset, waits for
// the reset-handler fetch, and records the kill cause and a saturating kill count.
module kill_rst_seq #(
    parameter int unsigned N_SRC           = 4,
    parameter logic [15:0] RESET_HANDLER   = 16'hFFFE,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned RELEASE_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] kill_req,
    input  logic [15:0]      pc,
    output logic             sys_rst,
    output logic [N_SRC-1:0] rst_cause,
    output logic [7:0]       kill_cnt,
    output logic             timeout_err,
    output logic             busy
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(RELEASE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [N_SRC-1:0]   cause_d;
    logic [7:0]         cnt_d;
    logic               terr_d;

    // Next-state and next-value logic for all registered outputs
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        cause_d = rst_cause;
        cnt_d   = kill_cnt;
        terr_d  = timeout_err;
        case (state_q)
            ST_IDLE: begin
                if (|kill_req) begin
                    state_d = ST_ASSERT;
                    cause_d = kill_req;
                    hold_d  = '0;
                    if (kill_cnt != 8'hFF) begin
                        cnt_d = kill_cnt + 8'd1;
                    end
                end
            end
            ST_ASSERT: begin
                cause_d = rst_cause | kill_req;
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RELEASE;
                    tmo_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                cause_d = rst_cause | kill_req;
                // Handler fetch beats a timeout landing on the same edge
                if (pc == RESET_HANDLER) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_W'(RELEASE_TIMEOUT - 1)) begin
                    state_d = ST_ASSERT;
                    terr_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            tmo_q       <= '0;
            sys_rst     <= 1'b0;
            rst_cause   <= '0;
            kill_cnt    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            sys_rst     <= (state_d == ST_ASSERT);
            rst_cause   <= cause_d;
            kill_cnt    <= cnt_d;
            timeout_err <= terr_d;
            busy        <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_kill_rst_seq.sv
// Directed self-checking bench for kill_rst_seq; inputs driven and outputs
// sampled on the falling edge, away from the active rising edge.
module tb_kill_rst_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  kill_req;
    logic [15:0] pc;
    logic        sys_rst;
    logic [3:0]  rst_cause;
    logic [7:0]  kill_cnt;
    logic        timeout_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    kill_rst_seq #(
        .N_SRC(4),
        .RESET_HANDLER(16'hFFFE),
        .HOLD_CYCLES(8),
        .RELEASE_TIMEOUT(256)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kill_req(kill_req),
        .pc(pc),
        .sys_rst(sys_rst),
        .rst_cause(rst_cause),
        .kill_cnt(kill_cnt),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; kill_req = '0; pc = '0;
        step();
        rst_n = 1'b1;
    endtask

    // One complete kill: trigger, 8-cycle hold, handler fetch back to IDLE
    task automatic run_kill(input logic [3:0] mask);
        kill_req = mask;
        step();
        kill_req = '0;
        repeat (8) step();
        pc = 16'hFFFE;
        step();
        pc = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; kill_req = 4'hF; pc = '0;
        step(); step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL reset_sys_rst: got %b want 0", sys_rst); end
        checks++; if (rst_cause !== 4'h0) begin errors++; $display("FAIL reset_cause: got %b want 0000", rst_cause); end
        checks++; if (kill_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", kill_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        kill_req = '0; rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_kill_ignored: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        do_reset();
        kill_req = 4'b0001;
        step();
        kill_req = '0;
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL basic_rise: sys_rst got %b want 1", sys_rst); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (rst_cause !== 4'b0001) begin errors++; $display("FAIL basic_cause: got %b want 0001", rst_cause); end
        checks++; if (kill_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", kill_cnt); end
        for (int i = 2; i <= 8; i++) begin
            step();
            checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL basic_hold cycle %0d: sys_rst got %b want 1", i, sys_rst); end
        end
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL basic_fall: sys_rst got %b want 0", sys_rst); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_release_busy: got %b want 1", busy); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_wait_busy: got %b want 1", busy); end
        pc = 16'hFFFE;
        step();
        pc = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_handler: busy got %b want 0", busy); end
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL basic_idle_rst: got %b want 0", sys_rst); end
    endtask

    task automatic test_cause_merge();
        do_reset();
        kill_req = 4'b0001; step();
        kill_req = 4'b0100; step();
        kill_req = '0;
        repeat (7) step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL merge_in_release: sys_rst got %b want 0", sys_rst); end
        kill_req = 4'b1000; step();
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL merge_no_restart: sys_rst got %b want 0", sys_rst); end
        // Request held through the handler fetch, dropped right after
        pc = 16'hFFFE; step();
        pc = '0; kill_req = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL merge_handler: busy got %b want 0", busy); end
        checks++; if (rst_cause !== 4'b1101) begin errors++; $display("FAIL merge_cause: got %b want 1101", rst_cause); end
        checks++; if (kill_cnt !== 8'd1) begin errors++; $display("FAIL merge_cnt: got %0d want 1", kill_cnt); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL merge_no_retrigger: busy got %b want 0", busy); end
        checks++; if (rst_cause !== 4'b1101) begin errors++; $display("FAIL merge_cause_hold: got %b want 1101", rst_cause); end
        kill_req = 4'b0010; step();
        kill_req = '0;
        checks++; if (rst_cause !== 4'b0010) begin errors++; $display("FAIL merge_overwrite: got %b want 0010", rst_cause); end
        checks++; if (kill_cnt !== 8'd2) begin errors++; $display("FAIL merge_cnt2: got %0d want 2", kill_cnt); end
        repeat (8) step();
        pc = 16'hFFFE; step(); pc = '0;
        kill_req = 4'b0110; step(); kill_req = '0;
        checks++; if (rst_cause !== 4'b0110) begin errors++; $display("FAIL multi_cause: got %b want 0110", rst_cause); end
        checks++; if (kill_cnt !== 8'd3) begin errors++; $display("FAIL multi_cnt: got %0d want 3", kill_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        kill_req = 4'b0001; step(); kill_req = '0;
        repeat (8) step();
        repeat (255) step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL tmo_before: sys_rst got %b want 0", sys_rst); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_before_err: got %b want 0", timeout_err); end
        step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL tmo_retry: sys_rst got %b want 1", sys_rst); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
        checks++; if (kill_cnt !== 8'd1) begin errors++; $display("FAIL tmo_cnt: got %0d want 1", kill_cnt); end
        repeat (7) step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL tmo_hold_end: sys_rst got %b want 1", sys_rst); end
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL tmo_fall: sys_rst got %b want 0", sys_rst); end
        pc = 16'hFFFE; step(); pc = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_handler: busy got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_tmo_priority();
        do_reset();
        kill_req = 4'b0001; step(); kill_req = '0;
        repeat (8) step();
        repeat (255) step();
        pc = 16'hFFFE; step(); pc = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b want 0", busy); end
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL prio_sys_rst: got %b want 0", sys_rst); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL prio_terr: got %b want 0", timeout_err); end
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL prio_no_retry: sys_rst got %b want 0", sys_rst); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            run_kill(4'b0001);
            if (i == 254) begin
                checks++; if (kill_cnt !== 8'hFE) begin errors++; $display("FAIL sat_254: got %h want fe", kill_cnt); end
            end
            if (i == 255) begin
                checks++; if (kill_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h want ff", kill_cnt); end
            end
        end
        checks++; if (kill_cnt !== 8'hFF) begin errors++; $display("FAIL sat_300: got %h want ff", kill_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_kill(4'b0010);
        kill_req = 4'b0001; step();
        step(); step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL mid_pre: sys_rst got %b want 1", sys_rst); end
        rst_n = 1'b0; step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL mid_sys_rst: got %b want 0", sys_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (kill_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", kill_cnt); end
        checks++; if (rst_cause !== 4'b0000) begin errors++; $display("FAIL mid_cause: got %b want 0000", rst_cause); end
        rst_n = 1'b1; step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL mid_fresh: sys_rst got %b want 1", sys_rst); end
        checks++; if (kill_cnt !== 8'd1) begin errors++; $display("FAIL mid_fresh_cnt: got %0d want 1", kill_cnt); end
        repeat (7) step();
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL mid_hold8: sys_rst got %b want 1", sys_rst); end
        step();
        checks++; if (sys_rst !== 1'b0) begin errors++; $display("FAIL mid_fall: sys_rst got %b want 0", sys_rst); end
        checks++; if (kill_cnt !== 8'd1) begin errors++; $display("FAIL mid_cnt_hold: got %0d want 1", kill_cnt); end
        kill_req = '0;
        pc = 16'hFFFE; step(); pc = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_handler: busy got %b want 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; kill_req = '0; pc = '0;
        test_reset();
        test_basic();
        test_cause_merge();
        test_timeout();
        test_tmo_priority();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kill_rst_seq.md
# kill_rst_seq

Reset sequencer on the consuming end of the hardware access monitors. It takes the level kill requests raised by the monitors when they detect an SDATA, KMEM or HMAC access violation, and drives a timed, active-high system reset into the MCU core. It then waits for the core to fetch the reset handler before re-arming. It also latches which monitor fired and keeps a saturating count of kill events for the attestation software.

## Interface
- N_SRC, 4, number of kill request sources (bit 0 = memory access monitor; others = atomicity/DMA monitors)
- RESET_HANDLER, 16'hFFFE, PC value that marks completion of the core reset
- HOLD_CYCLES, 8, cycles sys_rst is held high per assertion (≥1)
- RELEASE_TIMEOUT, 256, cycles to wait in RELEASE for the handler fetch before retrying (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low block reset
- kill_req  input  N_SRC  level kill requests from monitors, sampled each edge
- pc  input  16  current core program counter
- sys_rst  output  1  registered reset to the core, active high
- rst_cause  output  N_SRC  sources that caused the current or most recent kill
- kill_cnt  output  8  kill events since rst_n, saturating at 8'hFF
- timeout_err  output  1  sticky: a RELEASE timeout has occurred since rst_n
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ASSERT, RELEASE. All outputs are registered.
- rst_n low at an edge forces the following, overriding all else:
  - state = IDLE, sys_rst = 0, rst_cause = 0, kill_cnt = 0, timeout_err = 0, busy = 0
  - hold and timeout counters cleared
- IDLE:
  - Condition: |kill_req.
  - Action: go to ASSERT, rst_cause <= kill_req (overwrite), kill_cnt += 1 (saturating), hold counter = 0.
- ASSERT:
  - sys_rst = 1. Each cycle rst_cause |= kill_req (no count change).
  - After HOLD_CYCLES cycles in ASSERT, go to RELEASE with timeout counter = 0.
- RELEASE:
  - sys_rst = 0. rst_cause |= kill_req.
  - pc == RESET_HANDLER → IDLE.
  - Else, timeout counter reaching RELEASE_TIMEOUT-1 → ASSERT (retry): timeout_err <= 1, hold counter = 0, kill_cnt unchanged.
  - Otherwise the timeout counter increments.
- Priority in RELEASE: pc match wins over timeout in the same cycle.
- A kill_req still high in RELEASE does not restart ASSERT; only the timeout does.
- rst_cause holds its value in IDLE until the next kill; software reads it after reboot.
- kill_cnt saturates at 8'hFF; further kills keep 8'hFF.

## Timing
- kill_req high at edge k while in IDLE:
  - sys_rst, busy and the rst_cause update are visible after edge k.
  - sys_rst high for exactly HOLD_CYCLES cycles (edges k+1 … k+HOLD_CYCLES inclusive of state ASSERT).
  - sys_rst low after edge k+HOLD_CYCLES.
- Handler fetch: pc == RESET_HANDLER sampled at edge m in RELEASE → busy low after edge m. kill_req is sampled again in IDLE from edge m+1.
  - A monitor that drops its request one cycle after the handler fetch is therefore already low at m+1 and does not retrigger.
- Timeout: with no pc match, RELEASE lasts RELEASE_TIMEOUT cycles, then sys_rst rises again for HOLD_CYCLES.
- kill_req asserted in the same cycle rst_n is low: ignored; sampling starts at the first edge with rst_n high.
- Multi-bit kill_req: all bits present at the triggering edge appear in rst_cause together; kill_cnt increments by 1.

## Test plan
- HOLD_CYCLES=8, kill_req=4'b0001 for 1 cycle in IDLE:
  - sys_rst high exactly 8 cycles, then low.
  - rst_cause=4'b0001, kill_cnt=1, busy high until pc=16'hFFFE, low the cycle after.
- kill_req=4'b0001 at trigger, 4'b0100 during ASSERT, 4'b1000 during RELEASE:
  - rst_cause=4'b1101, kill_cnt=1.
  - Next kill 4'b0010 from IDLE overwrites rst_cause to 4'b0010, kill_cnt=2.
- RELEASE with pc never 16'hFFFE, RELEASE_TIMEOUT=256:
  - After 256 cycles sys_rst re-asserts for 8 cycles, timeout_err=1, kill_cnt unchanged.
  - pc=16'hFFFE then returns to IDLE.
- pc=16'hFFFE on the exact cycle the timeout counter hits 255: go to IDLE, timeout_err stays 0, no re-assertion.
- 300 kill/handler cycles: kill_cnt reaches 8'hFF and stays 8'hFF.
- rst_n low during ASSERT (cycle 3 of 8): next cycle all outputs are 0 and state is IDLE.
  - rst_n high with kill_req still high then starts a fresh 8-cycle assertion, kill_cnt=1.
